// File: rtl/ldl_rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant, grant lock until release,
// and optional hold-time preemption when other requesters are waiting.
module ldl_rr_arbiter #(
   parameter  int N        = 8,
   parameter  int MAX_HOLD = 0,
   localparam int IDX_W    = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req,
   output logic [N-1:0]     gnt,
   output logic             gnt_vld,
   output logic [IDX_W-1:0] gnt_idx,
   output logic [IDX_W-1:0] ptr
);

   localparam int HC_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HC_W-1:0] HOLD_LAST = HC_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   // Rotate r right by p, pick the lowest set bit, rotate the index back.
   function automatic logic [IDX_W-1:0] f_winner(input logic [N-1:0] r,
                                                 input logic [IDX_W-1:0] p);
      logic [N-1:0] rot;
      int           off;
      int           sum;
      rot = N'({r, r} >> p);
      // NOTE: default before the scan so every path yields a value and no latch is implied.
      off = 0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) off = i;
      end
      sum = int'(p) + off;
      if (sum >= N) sum = sum - N;
      return IDX_W'(sum);
   endfunction

   function automatic logic [N-1:0] f_onehot(input logic [IDX_W-1:0] idx);
      logic [N-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   state_t           r_state;
   logic [N-1:0]     r_gnt;
   logic             r_vld;
   logic [IDX_W-1:0] r_idx;
   logic [IDX_W-1:0] r_ptr;
   logic [HC_W-1:0]  r_hold;

   logic [IDX_W-1:0] w_next;
   logic [N-1:0]     w_others;
   logic [IDX_W-1:0] w_win_idle;
   logic [IDX_W-1:0] w_win_rel;
   logic [IDX_W-1:0] w_win_pre;
   logic             w_preempt;

   assign w_next     = (r_idx == IDX_W'(N - 1)) ? '0 : r_idx + 1'b1;
   assign w_others   = req & ~r_gnt;
   assign w_win_idle = f_winner(req, r_ptr);
   assign w_win_rel  = f_winner(req, w_next);
   assign w_win_pre  = f_winner(w_others, w_next);
   // Only consulted once the holder is known to still be requesting.
   assign w_preempt  = (MAX_HOLD > 0) && (r_hold == HOLD_LAST) && (|w_others);

   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_gnt   <= '0;
         r_vld   <= 1'b0;
         r_idx   <= '0;
         r_ptr   <= '0;
         r_hold  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (|req) begin
                  r_gnt   <= f_onehot(w_win_idle);
                  r_vld   <= 1'b1;
                  r_idx   <= w_win_idle;
                  r_hold  <= '0;
                  r_state <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (!req[r_idx]) begin
                  r_ptr  <= w_next;
                  r_hold <= '0;
                  if (|req) begin
                     r_gnt <= f_onehot(w_win_rel);
                     r_idx <= w_win_rel;
                  end else begin
                     r_gnt   <= '0;
                     r_vld   <= 1'b0;
                     r_state <= S_IDLE;
                  end
               end else if (w_preempt) begin
                  r_ptr  <= w_next;
                  r_hold <= '0;
                  r_gnt  <= f_onehot(w_win_pre);
                  r_idx  <= w_win_pre;
               end else if (r_hold != HOLD_LAST) begin
                  r_hold <= r_hold + 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign gnt     = r_gnt;
   assign gnt_vld = r_vld;
   assign gnt_idx = r_idx;
   assign ptr     = r_ptr;

endmodule

// File: doc/ldl_rr_arbiter.md
Name: ldl_rr_arbiter

Overview:
- Round-robin arbiter that shares one resource among N requesters, with grant lock and optional hold-time preemption.
- Fairness comes from a rotating priority pointer. Combinationally, the request vector is ring-rotated by the pointer, the lowest set bit is picked, and the result is rotated back.
- Grant is registered.
- Sits in front of any shared datapath, e.g. a shared shifter, bus or memory port.

Parameters:
- N, 8, number of requesters (N >= 2).
- MAX_HOLD, 0, maximum consecutive grant cycles per holder when others are waiting; 0 disables preemption.
- IDX_W, $clog2(N), derived localparam; width of index and pointer.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  request vector. A requester holds its bit high for the whole time it needs the resource.
- gnt  output  N  one-hot grant, registered; all-zero when idle.
- gnt_vld  output  1  high when any gnt bit is set.
- gnt_idx  output  IDX_W  binary index of the granted requester; holds its last value when gnt_vld=0.
- ptr  output  IDX_W  current priority pointer, for debug/verification.

Behaviour:
- Reset (async assert, sync deassert by system): gnt=0, gnt_vld=0, gnt_idx=0, ptr=0, hold_cnt=0, state=IDLE.
  - Reset mid-grant drops gnt immediately, without waiting for a clock edge.
- Winner function W(r,p): first set bit of r scanning p, p+1, …, N-1, 0, …, p-1 (wrap-around). Undefined if r=0; never used then.
- States: IDLE, BUSY.
- IDLE:
  - If |req at a rising edge: gnt <= onehot(W(req,ptr)), gnt_idx <= W, hold_cnt <= 0, state -> BUSY.
  - Latency: request visible at edge k, grant asserted after edge k.
  - If req=0: stay IDLE, outputs unchanged (gnt=0).
- BUSY, evaluated at each edge with holder h=gnt_idx:
  - Release: req[h]=0.
    - ptr <= (h+1) mod N.
    - If req!=0, grant W(req,(h+1) mod N) at the same edge (back-to-back, no dead cycle); hold_cnt <= 0; stay BUSY.
    - Else gnt <= 0, state -> IDLE.
  - Preempt (MAX_HOLD>0 only): req[h]=1, hold_cnt==MAX_HOLD-1, and (req & ~gnt)!=0.
    - ptr <= (h+1) mod N.
    - Grant W(req & ~gnt,(h+1) mod N); hold_cnt <= 0.
    - The holder therefore sees gnt for exactly MAX_HOLD cycles.
  - Otherwise keep gnt. hold_cnt increments and saturates at MAX_HOLD-1; it does not wrap.
  - A holder alone on the bus is never preempted.
- ptr changes only on release or preempt, never on the initial grant from IDLE.
- ptr wraps N-1 -> 0. For N not a power of two, ptr never takes values >= N.
- gnt is always one-hot or zero. gnt_vld == |gnt. gnt_idx == encode(gnt) whenever gnt_vld=1.
- Requests arriving mid-grant are ignored until the next release or preempt edge.
- Simultaneous release of h and new requests: all resolve at the same edge per W.
- hold_cnt width is $clog2(MAX_HOLD) bits, minimum 1.
- No combinational path from req to gnt.

Test Plan (N=4):
- Reset: assert rst mid-run while gnt=0010 -> gnt=0000, gnt_vld=0, gnt_idx=0, ptr=0 before the next clk edge; all outputs stay 0 after deassert with req=0.
- Single requester: req=0100 at edge k -> gnt=0100, gnt_idx=2 after edge k, ptr=0. Drop req -> gnt=0000 next edge, ptr=3, state IDLE.
- Fairness: req=1111, each holder drops its bit 2 cycles after its grant and re-raises it the next cycle -> grant order 0,1,2,3,0,1, with no idle cycle between grants.
- Wrap: ptr=3, then req=0011 -> gnt=0001 (bit 3 empty, wraps to 0). After release, ptr=1 and next grant is bit 1.
- Preempt, MAX_HOLD=4: req[1] held permanently, req[3] raised while 1 is granted -> gnt=0010 for exactly 4 cycles, then gnt=1000, ptr=2. With req[3] absent, gnt=0010 is held indefinitely.
- Back-to-back release: holder 2 drops while req=1011 -> gnt=1000 at the same edge, ptr=3.
